// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs (package)
// Brief    : Shared state, opcode, memory-command and write-back-select codes.
// Revision : 1.0
// ============================================================================
package cpu_defs;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B,
    S_ALU, S_WRITE_REG, S_ADDR, S_LOAD_ADDR, S_MEM_RD, S_WR_MDATA, S_PASS_B,
    S_MEM_WR, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    I_MOV_IMM, I_MOV_REG, I_ADD_AND, I_CMP, I_MVN, I_LDR, I_STR, I_HALT
  } iclass_e;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  // Unrecognised opcode/op combinations collapse to HALT.
  function automatic iclass_e classify(input logic [2:0] opcode, input logic [1:0] op);
    iclass_e c;
    c = I_HALT;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      c = I_MOV_IMM;
        else if (op == OP_MOV_REG) c = I_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD, OP_AND: c = I_ADD_AND;
          OP_CMP:         c = I_CMP;
          OP_MVN:         c = I_MVN;
          default:        c = I_HALT;
        endcase
      end
      OPC_LDR:  if (op == OP_MEM) c = I_LDR;
      OPC_STR:  if (op == OP_MEM) c = I_STR;
      OPC_HALT: c = I_HALT;
      default:  c = I_HALT;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/en_reg.sv
`default_nettype none
// ============================================================================
// Module   : en_reg
// Brief    : Enabled flop register with asynchronous active-low reset value.
// Revision : 1.0
// ============================================================================
module en_reg #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_o <= RESET_VAL;
    else if (en_i) q_o <= d_i;
  end

endmodule
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Brief    : Splits the instruction register into fields and sign-extended immediates.
// Revision : 1.0
// ============================================================================
module instr_decoder (
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  sh_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Brief    : Moore FSM sequencing fetch/decode/execute for the 16-bit datapath.
// Revision : 1.0
// ============================================================================
module cpu_controller
  import cpu_defs::*;
#(
  parameter int          PC_W     = 9,
  parameter int unsigned START_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     mdata,
  input  logic            N,
  input  logic            V,
  input  logic            Z,
  input  logic [15:0]     out,
  output logic [1:0]      mem_cmd,
  output logic [PC_W-1:0] mem_addr,
  output logic [15:0]     sximm5,
  output logic [15:0]     sximm8,
  output logic [PC_W-1:0] PC,
  output logic [2:0]      read_write_num,
  output logic [1:0]      shift,
  output logic [1:0]      ALUop,
  output logic [1:0]      vsel,
  output logic            write,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            asel,
  output logic            bsel,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, daddr_q, daddr_d;
  logic [15:0]     ir_q;
  logic [2:0]      w_opcode, w_rn, w_rd, w_rm;
  logic [1:0]      w_op, w_sh;
  iclass_e         w_cls;

  // Status flags and the upper bits of C do not influence sequencing.
  logic unused_ok;
  assign unused_ok = ^{N, V, Z, out};

  assign pc_d    = pc_q + PC_W'(1);
  assign daddr_d = out[PC_W-1:0];
  assign PC      = pc_q;

  en_reg #(.WIDTH(PC_W), .RESET_VAL(PC_W'(START_PC))) u_pc (
    .clk(clk), .rst_n(reset), .en_i(state_q == S_UPDATE_PC), .d_i(pc_d), .q_o(pc_q)
  );

  en_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) u_ir (
    .clk(clk), .rst_n(reset), .en_i(state_q == S_IF2), .d_i(mdata), .q_o(ir_q)
  );

  en_reg #(.WIDTH(PC_W), .RESET_VAL('0)) u_daddr (
    .clk(clk), .rst_n(reset), .en_i(state_q == S_LOAD_ADDR), .d_i(daddr_d), .q_o(daddr_q)
  );

  instr_decoder u_dec (
    .ir_i(ir_q), .opcode_o(w_opcode), .op_o(w_op), .rn_o(w_rn), .rd_o(w_rd),
    .rm_o(w_rm), .sh_o(w_sh), .sximm5_o(sximm5), .sximm8_o(sximm8)
  );

  assign w_cls = classify(w_opcode, w_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:       state_d = S_IF1;
      S_IF1:       state_d = S_IF2;
      S_IF2:       state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE: begin
        case (w_cls)
          I_MOV_IMM:                     state_d = S_WRITE_IMM;
          I_MOV_REG, I_MVN:              state_d = S_GET_B;
          I_ADD_AND, I_CMP, I_LDR, I_STR: state_d = S_GET_A;
          default:                       state_d = S_HALT;
        endcase
      end
      S_WRITE_IMM: state_d = S_IF1;
      S_GET_A:     state_d = (w_cls == I_LDR || w_cls == I_STR) ? S_ADDR : S_GET_B;
      S_GET_B:     state_d = (w_cls == I_STR) ? S_PASS_B : S_ALU;
      S_ALU:       state_d = (w_cls == I_CMP) ? S_IF1 : S_WRITE_REG;
      S_WRITE_REG: state_d = S_IF1;
      S_ADDR:      state_d = S_LOAD_ADDR;
      S_LOAD_ADDR: state_d = (w_cls == I_LDR) ? S_MEM_RD : S_GET_B;
      S_MEM_RD:    state_d = S_WR_MDATA;
      S_WR_MDATA:  state_d = S_IF1;
      S_PASS_B:    state_d = S_MEM_WR;
      S_MEM_WR:    state_d = S_IF1;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_RST;
    endcase
  end

  always_comb begin
    mem_cmd        = MEM_NONE;
    mem_addr       = pc_q;
    read_write_num = w_rn;
    shift          = 2'b00;
    ALUop          = 2'b00;
    vsel           = VSEL_MDATA;
    write          = 1'b0;
    loada          = 1'b0;
    loadb          = 1'b0;
    loadc          = 1'b0;
    loads          = 1'b0;
    asel           = 1'b0;
    bsel           = 1'b0;
    halted         = 1'b0;
    case (state_q)
      S_IF1, S_IF2: mem_cmd = MEM_READ;
      S_WRITE_IMM: begin
        write = 1'b1;
        vsel  = VSEL_IMM8;
      end
      S_GET_A: loada = 1'b1;
      S_GET_B: begin
        loadb          = 1'b1;
        read_write_num = (w_cls == I_STR) ? w_rd : w_rm;
      end
      S_ALU: begin
        // MOV-reg and MVN pass B alone, so A is forced to zero.
        loadc = 1'b1;
        shift = w_sh;
        ALUop = (w_cls == I_MOV_REG) ? 2'b00 : w_op;
        asel  = (w_cls == I_MOV_REG) || (w_cls == I_MVN);
        loads = (w_cls == I_CMP);
      end
      S_WRITE_REG: begin
        write          = 1'b1;
        vsel           = VSEL_C;
        read_write_num = w_rd;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_RD: begin
        mem_cmd  = MEM_READ;
        mem_addr = daddr_q;
      end
      S_WR_MDATA: begin
        mem_cmd        = MEM_READ;
        mem_addr       = daddr_q;
        write          = 1'b1;
        vsel           = VSEL_MDATA;
        read_write_num = w_rd;
      end
      S_PASS_B: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_WR: begin
        mem_cmd  = MEM_WRITE;
        mem_addr = daddr_q;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
